muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit.
// Holds the FSM state encoding, the op select values and the default iteration count.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned ITER_DEFAULT = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed 32x32 multiplier (radix-2 Booth) and restoring divider.
// Both share one 65-bit accumulator/shift register; one step per RUN cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [63:0] result
);

  localparam int unsigned CntW = $clog2(ITER + 1);

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            op_q;
  logic            neg_quot;
  logic            neg_rem;
  logic [31:0]     mcand;
  logic [64:0]     acc;

  logic [64:0]     acc_step;
  logic [32:0]     sum33;
  logic [32:0]     rsh;
  logic [33:0]     diff;
  logic [31:0]     quot;
  logic [31:0]     rem;
  logic [63:0]     fix_res;

  // MUL layout: {A[32:0], Q[31:0]} with acc[0] doubling as Booth's Q[-1] after the shift.
  // A is kept 33 bits wide so A - M cannot overflow when M is the most negative value.
  // DIV layout: {R[32:0], Q[31:0]}; Q starts as |dividend| and fills with quotient bits.
  always_comb begin
    sum33    = {acc[64], acc[64:33]};
    rsh      = acc[63:31];
    diff     = {1'b0, rsh} - {2'b00, mcand};
    acc_step = acc;
    if (op_q == OP_MUL) begin
      unique case (acc[1:0])
        2'b01:   sum33 = {acc[64], acc[64:33]} + {mcand[31], mcand};
        2'b10:   sum33 = {acc[64], acc[64:33]} - {mcand[31], mcand};
        default: sum33 = {acc[64], acc[64:33]};
      endcase
      acc_step = {sum33, acc[32:1]};
    end else begin
      acc_step = diff[33] ? {rsh, acc[30:0], 1'b0} : {diff[32:0], acc[30:0], 1'b1};
    end
  end

  always_comb begin
    quot    = neg_quot ? -acc[31:0] : acc[31:0];
    rem     = neg_rem ? -acc[63:32] : acc[63:32];
    fix_res = (op_q == OP_MUL) ? acc[64:1] : {rem, quot};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      cnt      <= '0;
      op_q     <= OP_MUL;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            op_q     <= op;
            cnt      <= '0;
            neg_quot <= a[31] ^ b[31];
            neg_rem  <= a[31];
            if (op == OP_DIV && b == '0) begin
              dbz    <= 1'b1;
              result <= {a, 32'hFFFF_FFFF};
              done   <= 1'b1;
              state  <= StDone;
            end else begin
              dbz   <= 1'b0;
              state <= StRun;
              if (op == OP_MUL) begin
                mcand <= a;
                acc   <= {33'b0, b, 1'b0};
              end else begin
                mcand <= abs32(b);
                acc   <= {33'b0, abs32(a)};
              end
            end
          end
        end
        StRun: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CntW'(ITER - 1)) state <= StFix;
        end
        StFix: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= StDone;
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic signed multiply/divide model.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {dbz, result} from signed arithmetic on the operands.
  function automatic logic [64:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 1'b0) begin
      p = sx * sy;
      return {1'b0, p[63:0]};
    end
    if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Runs one op; pulse_at >= 0 pulses start at that run cycle to check it is ignored.
  task automatic do_op(input string name, input logic o, input logic [31:0] x,
                       input logic [31:0] y, input int pulse_at);
    logic [64:0] m;
    int cycles, busy_cnt, extra;
    m = model(o, x, y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op = 1'($urandom); a = $urandom; b = $urandom;
    cycles = 0;
    busy_cnt = 0;
    while (1) begin
      if (busy) busy_cnt++;
      if (done || cycles >= 100) break;
      @(posedge clock); #1;
      cycles++;
      start = (cycles == pulse_at);
    end
    start = 1'b0;
    check({name, "_lat"}, 64'(cycles), m[64] ? 64'd0 : 64'd33);
    check({name, "_busy"}, 64'(busy_cnt), m[64] ? 64'd1 : 64'd34);
    check({name, "_res"}, result, m[63:0]);
    check({name, "_dbz"}, 64'(dbz), 64'(m[64]));
    @(posedge clock); #1;
    check({name, "_done_off"}, {62'b0, done, busy}, 64'd0);
    check({name, "_hold"}, {dbz, result[62:0]}, {m[64], m[62:0]});
    if (pulse_at >= 0) begin
      extra = 0;
      repeat (40) begin
        @(posedge clock); #1;
        if (done) extra++;
      end
      check({name, "_no_extra"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int cycles;
    logic [31:0] ra, rb;
    logic        ro;
    start = 1'b0; op = 1'b0; a = '0; b = '0;
    reset = 1'b0;
    #12;
    check("reset_state", {busy, done, dbz, result[60:0]}, 64'd0);
    @(negedge clock); reset = 1'b1;

    do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check("mul_7_m3_val", result, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    check("mul_min_min_val", result, 64'h4000_0000_0000_0000);
    do_op("mul_m1_1", 1'b0, 32'hFFFF_FFFF, 32'd1, -1);
    check("mul_m1_1_val", result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_m7_2_val", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);
    check("div_100_7_val", result, {32'd2, 32'd14});
    do_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_val", result, {32'h0, 32'h8000_0000});
    do_op("div_by0", 1'b1, 32'd5, 32'd0, -1);
    check("div_by0_val", {dbz, result[62:0]}, {1'b1, 31'h5, 32'hFFFF_FFFF});
    repeat (3) @(posedge clock);
    #1 check("dbz_sticky", 64'(dbz), 64'd1);
    do_op("mul_3_4", 1'b0, 32'd3, 32'd4, -1);
    check("mul_3_4_val", {dbz, result[62:0]}, 64'd12);
    do_op("start_in_run", 1'b1, 32'd1000, 32'hFFFF_FFFD, 5);

    // start held high: the next op is accepted on the first edge after DONE.
    @(negedge clock);
    op = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
    cycles = 0;
    @(posedge clock); #1;
    while (!done && cycles < 100) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("held_lat", 64'(cycles), 64'd33);
    @(posedge clock); #1;
    check("held_idle", 64'(busy), 64'd0);
    @(posedge clock); #1;
    check("held_restart", 64'(busy), 64'd1);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("held_res", result, 64'd30);
    @(posedge clock); #1;

    // Reset mid-run abandons the op immediately.
    @(negedge clock);
    op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1 check("rst_mid_run", {busy, done, dbz, result[60:0]}, 64'd0);
    repeat (3) @(posedge clock);
    check("rst_no_done", 64'(done), 64'd0);
    @(negedge clock); reset = 1'b1;
    do_op("mul_2_3", 1'b0, 32'd2, 32'd3, -1);
    check("mul_2_3_val", result, 64'd6);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'h8000_0000;
        4: rb = $urandom_range(1, 15);
        default: ;
      endcase
      do_op(ro ? "rnd_div" : "rnd_mul", ro, ra, rb, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
